// File: rtl/mic_frame_writer.sv
// Ping-pong frame writer: streams mic samples into a two-bank 512x16 RAM and hands full banks
// to a consumer. Define OVF_CNT_EN to add the saturating dropped-sample counter port ovf_cnt.
module mic_frame_writer #(
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  output logic        ram_cea,
  output logic [8:0]  ram_ada,
  output logic [15:0] ram_din,
  output logic        frm_valid,
  output logic        frm_bank,
  input  logic        frm_done,
  output logic        ovf,
`ifdef OVF_CNT_EN
  output logic [15:0] ovf_cnt,
`endif
  input  logic        ovf_clr
);

  localparam logic [7:0] LastPtr = 8'(FRAME_LEN - 1);

  typedef enum logic [0:0] {StFill, StStall} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_wr_bank, w_wr_bank_nxt;
  logic [7:0]  r_wr_ptr, w_wr_ptr_nxt;
  logic [1:0]  r_full, w_full_nxt, w_full_clr;

  logic        r_ram_cea;
  logic [8:0]  r_ram_ada;
  logic [15:0] r_ram_din;
  logic        r_frm_valid;
  logic        r_frm_bank;
  logic        r_ovf;

  logic        w_accept;
  logic        w_drop;
  logic        w_last;
  logic        w_release;

  assign w_accept  = s_valid && (r_state == StFill);
  assign w_drop    = s_valid && (r_state == StStall);
  assign w_last    = w_accept && (r_wr_ptr == LastPtr);
  assign w_release = frm_done && r_frm_valid;

  // A release in the same cycle as the last sample counts as already free, so no stall.
  always_comb begin
    w_full_clr    = 2'b00;
    w_state_nxt   = r_state;
    w_wr_bank_nxt = r_wr_bank;
    w_wr_ptr_nxt  = r_wr_ptr;
    if (w_release) begin
      w_full_clr[r_frm_bank] = 1'b1;
    end
    w_full_nxt = r_full & ~w_full_clr;

    unique case (r_state)
      StFill: begin
        if (w_accept) begin
          if (w_last) begin
            w_full_nxt[r_wr_bank] = 1'b1;
            w_wr_ptr_nxt          = 8'd0;
            if (!w_full_nxt[~r_wr_bank]) begin
              w_wr_bank_nxt = ~r_wr_bank;
            end else begin
              w_state_nxt = StStall;
            end
          end else begin
            w_wr_ptr_nxt = r_wr_ptr + 8'd1;
          end
        end
      end
      StStall: begin
        // Toggle together with the release so frm_valid never dips for the just-filled bank.
        if (!w_full_nxt[~r_wr_bank]) begin
          w_wr_bank_nxt = ~r_wr_bank;
          w_wr_ptr_nxt  = 8'd0;
          w_state_nxt   = StFill;
        end
      end
      default: begin
        w_state_nxt = StFill;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= StFill;
      r_wr_bank <= 1'b0;
      r_wr_ptr  <= 8'd0;
      r_full    <= 2'b00;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_bank <= w_wr_bank_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_full    <= w_full_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ram_cea <= 1'b0;
      r_ram_ada <= 9'd0;
      r_ram_din <= 16'd0;
    end else begin
      r_ram_cea <= w_accept;
      if (w_accept) begin
        r_ram_ada <= {r_wr_bank, r_wr_ptr};
        r_ram_din <= s_data;
      end
    end
  end

  // Sampled from registered state so frm_valid trails the committed RAM write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frm_valid <= 1'b0;
      r_frm_bank  <= 1'b1;
    end else begin
      r_frm_valid <= r_full[~r_wr_bank];
      r_frm_bank  <= ~r_wr_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_drop | (r_ovf & ~ovf_clr);
    end
  end

`ifdef OVF_CNT_EN
  logic [15:0] r_ovf_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf_cnt <= 16'd0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= {15'd0, w_drop};
    end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 16'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign ram_cea   = r_ram_cea;
  assign ram_ada   = r_ram_ada;
  assign ram_din   = r_ram_din;
  assign frm_valid = r_frm_valid;
  assign frm_bank  = r_frm_bank;
  assign ovf       = r_ovf;

endmodule
